// File: rtl/avmm_burst_onchip_ram_pkg.sv
// Shared types and helpers for the burst-capable on-chip RAM.
//   state_t   : burst FSM states
//   LAT       : read latency in cycles (1, or 2 with AVMM_RAM_OUTPUT_REG_EN)
//   norm_len  : burstcount normalisation (0 means a single beat)
// Optional feature macro: AVMM_RAM_OUTPUT_REG_EN
package avmm_ram_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } state_t;

    function automatic int read_lat();
`ifdef AVMM_RAM_OUTPUT_REG_EN
        return 2;
`else
        return 1;
`endif
    endfunction

    localparam int LAT = read_lat();

    function automatic logic [31:0] norm_len(input logic [31:0] bc);
        return (bc == 32'd0) ? 32'd1 : bc;
    endfunction

endpackage

// File: rtl/avmm_burst_onchip_ram_if.sv
// Avalon-MM slave bus bundle for avmm_burst_onchip_ram.
//   reset_req, address, clken, chipselect, write, read, burstcount,
//   writedata, byteenable   : master -> slave
//   readdata, readdatavalid, waitrequest : slave -> master
interface avmm_burst_onchip_ram_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int BURST_W = 4
);
    logic                  reset_req;
    logic [ADDR_W-1:0]     address;
    logic                  clken;
    logic                  chipselect;
    logic                  write;
    logic                  read;
    logic [BURST_W-1:0]    burstcount;
    logic [DATA_W-1:0]     writedata;
    logic [DATA_W/8-1:0]   byteenable;
    logic [DATA_W-1:0]     readdata;
    logic                  readdatavalid;
    logic                  waitrequest;

    modport master (
        output reset_req, address, clken, chipselect, write, read,
               burstcount, writedata, byteenable,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  reset_req, address, clken, chipselect, write, read,
               burstcount, writedata, byteenable,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/avmm_burst_onchip_ram_core.sv
// Byte-enabled single-port RAM, DEPTH x DATA_W, registered read port.
//   clk, reset : clock, async active-high reset (read register only)
//   we, be     : write strobe and per-byte enables
//   re         : read strobe; rdata updates only on a read
//   addr       : shared read/write word address
//   wdata      : write data
//   rdata      : registered read data
module avmm_ram_core #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic                re,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   rdata
);
    localparam int BE_W = DATA_W / 8;

    // Memory array carries no reset so it maps onto block RAM.
    logic [BE_W-1:0][7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) mem[addr][b] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)   rdata <= '0;
        else if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/avmm_burst_onchip_ram.sv
// Parametrised on-chip RAM with Avalon-MM slave: bursts with address
// auto-increment, pipelined reads with readdatavalid, waitrequest stall.
//   clk, reset : system clock, async active-high reset
//   bus        : avmm_burst_onchip_ram_if slave modport
// Optional feature macro: AVMM_RAM_OUTPUT_REG_EN (extra output register, LAT=2)
module avmm_burst_onchip_ram
    import avmm_ram_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int BURST_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    avmm_burst_onchip_ram_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    state_t               state, state_nxt;
    logic                 en;
    logic [ADDR_W-1:0]    ptr, ram_addr;
    logic [BURST_W-1:0]   rem, len;
    logic                 ram_we, ram_re;
    logic [DATA_W-1:0]    ram_q;
    logic [LAT-1:0]       vld_pipe;

    assign en  = bus.clken && !bus.reset_req;
    assign len = BURST_W'(norm_len(32'(bus.burstcount)));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; ram_we/ram_re already include en, so a frozen
    // cycle never advances the FSM.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ram_we && len != BURST_W'(1))      state_nxt = WR_BURST;
                else if (ram_re && len != BURST_W'(1)) state_nxt = RD_BURST;
            end
            WR_BURST: if (ram_we && rem == BURST_W'(1)) state_nxt = IDLE;
            RD_BURST: if (ram_re && rem == BURST_W'(1)) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = ptr;
        case (state)
            IDLE: begin
                ram_addr = bus.address;
                // Write wins when both are requested; the read is dropped.
                ram_we   = en && bus.chipselect && bus.write;
                ram_re   = en && bus.chipselect && bus.read && !bus.write;
            end
            // A beat offered while read is also high is stalled, not taken.
            WR_BURST: ram_we = en && bus.chipselect && bus.write && !bus.read;
            RD_BURST: ram_re = en;
            default: ;
        endcase
        bus.waitrequest = reset || !en || (state == RD_BURST) ||
                          (state == WR_BURST && bus.read);
    end

    // Burst pointer and remaining-beat counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
            rem <= '0;
        end else if (ram_we || ram_re) begin
            if (state == IDLE) begin
                ptr <= bus.address + 1'b1;
                rem <= len - 1'b1;
            end else begin
                ptr <= ptr + 1'b1;
                rem <= rem - 1'b1;
            end
        end
    end

    avmm_ram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (bus.writedata),
        .be    (bus.byteenable),
        .rdata (ram_q)
    );

    // Valid shift register; frozen with en so a pending beat survives a stall
    // and is presented once en returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   vld_pipe <= '0;
        else if (en) vld_pipe <= (vld_pipe << 1) | LAT'(ram_re);
    end

    assign bus.readdatavalid = vld_pipe[LAT-1] && en;

`ifdef AVMM_RAM_OUTPUT_REG_EN
    logic [DATA_W-1:0] out_q;

    // Load only with a valid beat so readdata holds between beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  out_q <= '0;
        else if (en && vld_pipe[0]) out_q <= ram_q;
    end

    assign bus.readdata = out_q;
`else
    assign bus.readdata = ram_q;
`endif

    a_rw_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(state == IDLE && en && bus.chipselect && bus.read && bus.write));

endmodule

// File: tb/tb_avmm_burst_onchip_ram.sv
module tb_avmm_burst_onchip_ram;
    import avmm_ram_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    avmm_burst_onchip_ram_if #(.DATA_W(32), .ADDR_W(8), .BURST_W(4)) bus ();

    avmm_burst_onchip_ram #(.DATA_W(32), .DEPTH(256), .BURST_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] rq[$];
    int          rc[$];
    logic [31:0] eq[$];
    int          ec[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every delivered beat with the cycle it appeared in.
    always @(posedge clk) begin
        #2;
        if (bus.readdatavalid === 1'b1) begin
            rq.push_back(bus.readdata);
            rc.push_back(cyc);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [3:0]  bc;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[13];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.clken      = 1'b1;
        bus.reset_req  = 1'b0;
        bus.address    = '0;
        bus.burstcount = '0;
        bus.writedata  = '0;
        bus.byteenable = '0;
    endtask

    task automatic cmd(bit wr, logic [7:0] a, logic [3:0] bc, logic [31:0] d, logic [3:0] be);
        bus.chipselect = 1'b1;
        bus.write      = wr;
        bus.read       = !wr;
        bus.address    = a;
        bus.burstcount = bc;
        bus.writedata  = d;
        bus.byteenable = be;
    endtask

    task automatic wbeat(logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.read       = 1'b0;
        bus.address    = 8'h00;   // ignored after the first beat
        bus.writedata  = d;
        bus.byteenable = 4'hF;
    endtask

    task automatic check_reads(string nm, bit use_cyc);
        int n;
        chk({nm, "_count"}, 32'(rq.size()), 32'(eq.size()));
        n = (rq.size() < eq.size()) ? rq.size() : eq.size();
        for (int i = 0; i < n; i++) begin
            chk({nm, "_data"}, rq[i], eq[i]);
            if (use_cyc) chk({nm, "_cycle"}, 32'(rc[i]), 32'(ec[i]));
        end
        rq.delete(); rc.delete(); eq.delete(); ec.delete();
    endtask

    initial begin
        int t0;
        int quiet;
        int n;

        vt[0]  = '{1'b1, 8'd5, 4'd1, 32'hDEADBEEF, 4'hF, 32'h0};
        vt[1]  = '{1'b0, 8'd5, 4'd1, 32'h0,        4'h0, 32'hDEADBEEF};
        vt[2]  = '{1'b1, 8'd7, 4'd1, 32'hFFFFFFFF, 4'hF, 32'h0};
        vt[3]  = '{1'b1, 8'd7, 4'd1, 32'h00000000, 4'h5, 32'h0};
        vt[4]  = '{1'b0, 8'd7, 4'd1, 32'h0,        4'h0, 32'hFF00FF00};
        vt[5]  = '{1'b1, 8'd9, 4'd0, 32'h12345678, 4'hF, 32'h0};
        vt[6]  = '{1'b0, 8'd9, 4'd0, 32'h0,        4'h0, 32'h12345678};
        vt[7]  = '{1'b1, 8'd0, 4'd1, 32'h11111111, 4'hF, 32'h0};
        vt[8]  = '{1'b1, 8'd1, 4'd1, 32'h22222222, 4'hF, 32'h0};
        vt[9]  = '{1'b1, 8'd2, 4'd1, 32'h33333333, 4'hF, 32'h0};
        vt[10] = '{1'b0, 8'd0, 4'd1, 32'h0,        4'h0, 32'h11111111};
        vt[11] = '{1'b0, 8'd1, 4'd1, 32'h0,        4'h0, 32'h22222222};
        vt[12] = '{1'b0, 8'd2, 4'd0, 32'h0,        4'h0, 32'h33333333};

        // Reset state
        bus_idle();
        reset = 1'b1;
        tick();
        tick();
        chk("rst_waitrequest",   32'(bus.waitrequest),   32'd1);
        chk("rst_readdatavalid", 32'(bus.readdatavalid), 32'd0);
        chk("rst_readdata",      bus.readdata,           32'd0);
        reset = 1'b0;
        #1;
        chk("idle_waitrequest",  32'(bus.waitrequest),   32'd0);
        tick();

        // Single-beat table: writes, byte enables, burstcount 0, b2b reads
        for (int i = 0; i < 13; i++) begin
            cmd(vt[i].wr, vt[i].addr, vt[i].bc, vt[i].data, vt[i].be);
            #1;
            chk("tbl_waitrequest", 32'(bus.waitrequest), 32'd0);
            if (!vt[i].wr) begin
                eq.push_back(vt[i].exp);
                ec.push_back(cyc + LAT);
            end
            tick();
        end
        bus_idle();
        repeat (4) tick();
        check_reads("tbl", 1'b1);

        // Write burst of 4 at 254 (wraps), gap after the first beat
        cmd(1'b1, 8'd254, 4'd4, 32'd1, 4'hF);
        #1;
        chk("wb_first_wait", 32'(bus.waitrequest), 32'd0);
        tick();
        bus.write = 1'b0;
        bus.read  = 1'b1;   // read during a write burst must stall
        #1;
        chk("wb_gap_wait", 32'(bus.waitrequest), 32'd1);
        tick();
        for (int d = 2; d <= 4; d++) begin
            wbeat(32'(d));
            #1;
            chk("wb_beat_wait", 32'(bus.waitrequest), 32'd0);
            tick();
        end
        bus_idle();
        #1;
        chk("wb_done_wait", 32'(bus.waitrequest), 32'd0);
        tick();

        // Read burst of 4 at 254
        cmd(1'b0, 8'd254, 4'd4, 32'h0, 4'h0);
        #1;
        chk("rb_first_wait", 32'(bus.waitrequest), 32'd0);
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            eq.push_back(32'(i + 1));
            ec.push_back(t0 + LAT + i);
        end
        tick();
        bus_idle();
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk("rb_busy_wait", 32'(bus.waitrequest), 32'd1);
            tick();
        end
        #1;
        chk("rb_done_wait", 32'(bus.waitrequest), 32'd0);
        repeat (4) tick();
        check_reads("burst_wrap", 1'b1);

        // Fill 16..23 for the stall and reset sequences
        cmd(1'b1, 8'd16, 4'd8, 32'h100, 4'hF);
        tick();
        for (int i = 1; i < 8; i++) begin
            wbeat(32'h100 + 32'(i));
            tick();
        end
        bus_idle();
        tick();

        // Read burst of 8 frozen for 3 cycles: clken (mode 0), reset_req (mode 1)
        for (int mode = 0; mode < 2; mode++) begin
            cmd(1'b0, 8'd16, 4'd8, 32'h0, 4'h0);
            t0 = cyc;
            tick();
            bus_idle();
            tick();
            tick();
            for (int k = 0; k < 3; k++) begin
                if (mode == 0) bus.clken = 1'b0;
                else           bus.reset_req = 1'b1;
                #1;
                chk("freeze_wait", 32'(bus.waitrequest),   32'd1);
                chk("freeze_rdv",  32'(bus.readdatavalid), 32'd0);
                tick();
            end
            bus.clken     = 1'b1;
            bus.reset_req = 1'b0;
            for (int i = 0; i < 5; i++) begin
                #1;
                chk("resume_wait", 32'(bus.waitrequest), 32'd1);
                tick();
            end
            #1;
            chk("freeze_end_wait", 32'(bus.waitrequest), 32'd0);
            repeat (5) tick();
            quiet = 0;
            foreach (rc[i]) if (rc[i] >= t0 + 3 && rc[i] <= t0 + 5) quiet++;
            chk("freeze_quiet", 32'(quiet), 32'd0);
            for (int i = 0; i < 8; i++) eq.push_back(32'h100 + 32'(i));
            check_reads(mode == 0 ? "freeze_clken" : "freeze_reset_req", 1'b0);
        end

        // Reset asserted after the second beat of a 6-beat read burst
        cmd(1'b0, 8'd16, 4'd6, 32'h0, 4'h0);
        tick();
        bus_idle();
        n = 0;
        while (rq.size() < 2 && n < 12) begin
            tick();
            #2;
            n++;
        end
        chk("mid_rst_two_beats", 32'(rq.size()), 32'd2);
        reset = 1'b1;
        #1;
        chk("mid_rst_rdv",   32'(bus.readdatavalid), 32'd0);
        chk("mid_rst_rdata", bus.readdata,           32'd0);
        tick();
        chk("mid_rst_wait",  32'(bus.waitrequest),   32'd1);
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_wait", 32'(bus.waitrequest), 32'd0);
        repeat (6) tick();
        eq.push_back(32'h100);
        eq.push_back(32'h101);
        check_reads("mid_rst_beats", 1'b0);

        // Contents survive reset
        cmd(1'b0, 8'd16, 4'd1, 32'h0, 4'h0);
        ec.push_back(cyc + LAT);
        eq.push_back(32'h100);
        tick();
        cmd(1'b0, 8'd23, 4'd0, 32'h0, 4'h0);
        ec.push_back(cyc + LAT);
        eq.push_back(32'h107);
        tick();
        bus_idle();
        repeat (4) tick();
        check_reads("reread", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
